// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// kgp_pkg : shared definitions for the KGP-RISC front end.
//   - Opcode constants seen on the opcode side of the control decoder.
//   - Fetch sequencer state encoding.
//   - Default reset PC and word/opcode widths.
//   - opcode_of() : extracts the primary opcode field of an instruction word.
// No ports (package).
// ---------------------------------------------------------------------------
package kgp_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  localparam logic [31:0] KGP_RESET_PC = 32'h0000_0000;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ITYPE = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_STORE = 6'b100001;
  localparam logic [OPCODE_W-1:0] OP_B     = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_BR    = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_BCOND = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_BL    = 6'b010011;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1:INSTR_W-OPCODE_W];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if : bundles every handshake/bus signal of the fetch sequencer.
//   Instruction memory : imem_req, imem_addr (to memory), imem_valid,
//                        imem_rdata (from memory).
//   Decode side        : instr_valid, instr, opcode, pc, link_addr (to decode),
//                        instr_ready (from decode).
//   Execute side       : br_taken, br_target (redirect from execute).
// Modports:
//   master : the fetch sequencer itself.
//   slave  : the surrounding environment (memory, decode, execute).
// ---------------------------------------------------------------------------
interface instr_fetch_if
  import kgp_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_valid;
  logic [INSTR_W-1:0]  imem_rdata;

  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   link_addr;

  logic                br_taken;
  logic [ADDR_W-1:0]   br_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output instr_valid, instr, opcode, pc, link_addr,
    input  instr_ready,
    input  br_taken, br_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  instr_valid, instr, opcode, pc, link_addr,
    output instr_ready,
    output br_taken, br_target
  );

endinterface

// File: rtl/instr_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter datapath of the fetch sequencer.
//   clk, reset  : clock and synchronous active-high reset.
//   redirect    : load target (word-aligned) into fetch_pc; wins over increment.
//   target      : redirect address; bits [1:0] are dropped.
//   increment   : advance fetch_pc by one word.
//   capture     : copy fetch_pc into pc (address of the instruction being issued).
//   fetch_pc    : address of the next/current fetch.
//   pc          : address of the issued instruction.
//   link_addr   : pc + 4, return address for bl.
// All arithmetic wraps modulo 2^ADDR_W.
// ---------------------------------------------------------------------------
module pc_unit
  import kgp_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(KGP_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  input  logic              increment,
  input  logic              capture,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr
);

  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0] fetch_pc_d, fetch_pc_q;
  logic [ADDR_W-1:0] pc_d, pc_q;

  // Next-state selection: a redirect always beats the sequential increment.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    if (redirect) begin
      fetch_pc_d = target & ALIGN_MASK;
    end else if (increment) begin
      fetch_pc_d = fetch_pc_q + WORD_STEP;
    end
    if (capture) begin
      pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
    end
  end

  assign fetch_pc  = fetch_pc_q;
  assign pc        = pc_q;
  // Derived from the pc register, so it is as stable as pc itself.
  assign link_addr = pc_q + WORD_STEP;

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : multi-cycle fetch/issue sequencer for the KGP-RISC core.
//   clk   : single clock, rising edge.
//   reset : synchronous, active-high.
//   bus   : instr_fetch_if.master
//           - imem_req/imem_addr out, imem_valid/imem_rdata in
//           - instr_valid/instr/opcode/pc/link_addr out, instr_ready in
//           - br_taken/br_target in
// Fetches one word at a time, holds it for decode until accepted, and applies
// branch redirects, discarding any fetch that is still in flight.
// ---------------------------------------------------------------------------
module instr_fetch
  import kgp_pkg::*;
#(
  parameter logic [31:0] RESET_PC = KGP_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic           clk,
  input  logic           reset,
  instr_fetch_if.master  bus
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  fetch_state_e        state_q;
  logic                imem_req_q;
  logic                instr_valid_q;
  logic [INSTR_W-1:0]  instr_q;
  logic [OPCODE_W-1:0] opcode_q;

  logic              pc_redirect;
  logic              pc_increment;
  logic              pc_capture;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] link_addr;

  // PC datapath controls. A redirect is honoured in every state, and it
  // suppresses both the sequential advance and the capture of a response.
  always_comb begin
    pc_redirect  = bus.br_taken;
    pc_increment = (state_q == S_ISSUE) && bus.instr_ready && !bus.br_taken;
    pc_capture   = (state_q == S_WAIT) && bus.imem_valid && !bus.br_taken;
  end

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC_W)
  ) u_pc_unit (
    .clk       (clk),
    .reset     (reset),
    .redirect  (pc_redirect),
    .target    (bus.br_target),
    .increment (pc_increment),
    .capture   (pc_capture),
    .fetch_pc  (fetch_pc),
    .pc        (pc),
    .link_addr (link_addr)
  );

  // Sequencer FSM with registered outputs. imem_req_q is raised on every
  // transition into FETCH so the request appears in the FETCH cycle itself.
  // The only FETCH cycle with imem_req_q low is the one right after reset;
  // it launches the first request and has nothing outstanding to drain.
  // In DRAIN a redirect only retargets fetch_pc; if the drained response
  // arrives in that same cycle the drain is complete, so the FSM still leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      opcode_q      <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_req_q) begin
            imem_req_q <= 1'b0;
            state_q    <= bus.br_taken ? S_DRAIN : S_WAIT;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.br_taken) begin
            if (bus.imem_valid) begin
              imem_req_q <= 1'b1;
              state_q    <= S_FETCH;
            end else begin
              state_q    <= S_DRAIN;
            end
          end else if (bus.imem_valid) begin
            instr_q       <= bus.imem_rdata;
            opcode_q      <= opcode_of(bus.imem_rdata);
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.br_taken || bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (bus.imem_valid) begin
            imem_req_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        default: begin
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = opcode_q;
  assign bus.pc          = pc;
  assign bus.link_addr   = link_addr;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed bench for instr_fetch. The bench plays memory,
// decode and execute through the slave side of instr_fetch_if. Memory words
// are {opcode, 10'h155, addr[15:0]} and are given as hand-written constants.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import kgp_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Step to just after the next rising edge, where outputs are sampled and
  // new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic br,
                               input logic [31:0] target);
    bus.instr_ready = ready;
    bus.br_taken    = br;
    bus.br_target   = target;
  endtask

  // Called in a request cycle: waits lat cycles, then pulses imem_valid for
  // one cycle. Returns in the cycle after the response.
  task automatic respond(input int lat, input logic [31:0] word);
    for (int i = 0; i < lat; i++) begin
      tick();
      checkOutput("req_low_in_wait", {31'b0, bus.imem_req}, 32'h0);
      checkOutput("valid_low_in_wait", {31'b0, bus.instr_valid}, 32'h0);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
  endtask

  // Latency-1 fetch with instr_ready high: checks the request, the issued
  // word, and the next request three cycles after this one.
  task automatic fetchFast(input logic [31:0] addr, input logic [31:0] word,
                           input logic [5:0] op);
    checkOutput("req_high", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("req_addr", bus.imem_addr, addr);
    respond(1, word);
    checkOutput("issue_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("issue_instr", bus.instr, word);
    checkOutput("issue_opcode", {26'b0, bus.opcode}, {26'b0, op});
    checkOutput("issue_pc", bus.pc, addr);
    checkOutput("issue_link", bus.link_addr, addr + 32'h4);
    tick();
    checkOutput("next_req_high", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("next_req_addr", bus.imem_addr, addr + 32'h4);
    checkOutput("valid_dropped", {31'b0, bus.instr_valid}, 32'h0);
  endtask

  task automatic doReset();
    reset          = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("first_req_high", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("first_req_addr", bus.imem_addr, 32'h0);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    reset          = 1'b1;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_opcode", {26'b0, bus.opcode}, 32'h0);
    checkOutput("rst_pc", bus.pc, 32'h0);
    checkOutput("rst_link", bus.link_addr, 32'h4);
    reset = 1'b0;
    tick();
    checkOutput("first_req_high", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("first_req_addr", bus.imem_addr, 32'h0);

    // Back-to-back latency-1 fetches, one every three cycles
    $display("[TB] streaming fetches");
    fetchFast(32'h0, 32'h0155_0000, 6'h00);
    fetchFast(32'h4, 32'h2155_0004, 6'h08);
    fetchFast(32'h8, 32'h4D55_0008, 6'h13);

    // Latency 4 with decode stalled for 5 cycles
    $display("[TB] stall in issue");
    doReset();
    fetchFast(32'h0, 32'h0155_0000, 6'h00);
    applyStimulus(1'b0, 1'b0, 32'h0);
    respond(4, 32'h2155_0004);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", {31'b0, bus.instr_valid}, 32'h1);
      checkOutput("hold_instr", bus.instr, 32'h2155_0004);
      checkOutput("hold_opcode", {26'b0, bus.opcode}, 32'h08);
      checkOutput("hold_pc", bus.pc, 32'h4);
      checkOutput("hold_link", bus.link_addr, 32'h8);
      checkOutput("hold_no_req", {31'b0, bus.imem_req}, 32'h0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("accept_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("accept_addr", bus.imem_addr, 32'h8);
    checkOutput("accept_valid", {31'b0, bus.instr_valid}, 32'h0);

    // Redirect in WAIT before the response: unaligned target, late response
    $display("[TB] redirect in wait");
    doReset();
    tick();
    applyStimulus(1'b1, 1'b1, 32'h0000_0041);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("drain_no_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    checkOutput("drain_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h0155_0000;
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    checkOutput("drained_no_issue", {31'b0, bus.instr_valid}, 32'h0);
    fetchFast(32'h40, 32'h0155_0040, 6'h00);

    // Redirect together with the response in WAIT
    $display("[TB] redirect with response");
    tick();
    checkOutput("wait_no_req", {31'b0, bus.imem_req}, 32'h0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h2155_0044;
    applyStimulus(1'b1, 1'b1, 32'h0000_0080);
    tick();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("same_cycle_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("same_cycle_addr", bus.imem_addr, 32'h80);
    checkOutput("same_cycle_no_issue", {31'b0, bus.instr_valid}, 32'h0);
    fetchFast(32'h80, 32'h0155_0080, 6'h00);

    // Redirect in ISSUE with instr_ready also high
    $display("[TB] redirect in issue");
    respond(1, 32'h2155_0084);
    checkOutput("br_issue_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("br_issue_instr", bus.instr, 32'h2155_0084);
    applyStimulus(1'b1, 1'b1, 32'h0000_0100);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("br_issue_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("br_issue_addr", bus.imem_addr, 32'h100);
    checkOutput("br_issue_dropped", {31'b0, bus.instr_valid}, 32'h0);
    fetchFast(32'h100, 32'h0155_0100, 6'h00);

    // Reset while an instruction is held in ISSUE
    $display("[TB] reset in issue");
    applyStimulus(1'b0, 1'b0, 32'h0);
    respond(1, 32'h2155_0104);
    checkOutput("pre_rst_valid", {31'b0, bus.instr_valid}, 32'h1);
    checkOutput("pre_rst_pc", bus.pc, 32'h104);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("mid_rst_pc", bus.pc, 32'h0);
    checkOutput("mid_rst_link", bus.link_addr, 32'h4);
    checkOutput("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("mid_rst_instr", bus.instr, 32'h0);
    checkOutput("mid_rst_opcode", {26'b0, bus.opcode}, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("restart_req", {31'b0, bus.imem_req}, 32'h1);
    checkOutput("restart_addr", bus.imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    fetchFast(32'h0, 32'h0155_0000, 6'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
